// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master between N_REQ clients:
// latches the winner's command, runs the newTXN handshake and a timeout watchdog.
module i2c_txn_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int N_REQ      = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ-1:0]                req_wr,
  input  logic [N_REQ*(DATA_WIDTH-1)-1:0] req_slv,
  input  logic [N_REQ*DATA_WIDTH-1:0]     req_reg,
  input  logic [N_REQ*DATA_WIDTH-1:0]     req_wdata,
  output logic [N_REQ-1:0]                gnt,
  output logic [N_REQ-1:0]                done,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic [1:0]                      err,
  output logic                            m_new_txn,
  output logic                            m_wr_en,
  output logic [DATA_WIDTH-2:0]           m_slv_addr,
  output logic [DATA_WIDTH-1:0]           m_reg_addr,
  output logic [DATA_WIDTH-1:0]           m_data,
  input  logic                            m_busy,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic                            m_nack
);
  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST  = PW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, COMPLETE} state_t;

  typedef struct packed {
    logic                  wr;
    logic [DATA_WIDTH-2:0] slv;
    logic [DATA_WIDTH-1:0] rga;
    logic [DATA_WIDTH-1:0] wdat;
  } cmd_t;

  state_t              state;
  logic [PW-1:0]       rr_ptr;
  logic [TW-1:0]       tmo_cnt;
  cmd_t [N_REQ-1:0]    cmd;
  cmd_t                win_cmd;
  logic [PW-1:0]       win_idx;
  logic [PW-1:0]       cand;
  logic                win_found;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign cmd[i].wr   = req_wr[i];
    assign cmd[i].slv  = req_slv[i*(DATA_WIDTH-1) +: (DATA_WIDTH-1)];
    assign cmd[i].rga  = req_reg[i*DATA_WIDTH +: DATA_WIDTH];
    assign cmd[i].wdat = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_cmd = cmd[win_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= PTR_RST;
      tmo_cnt    <= '0;
      gnt        <= '0;
      done       <= '0;
      rdata      <= '0;
      err        <= '0;
      m_new_txn  <= 1'b0;
      m_wr_en    <= 1'b0;
      m_slv_addr <= '0;
      m_reg_addr <= '0;
      m_data     <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_found && !m_busy) begin
            state      <= LAUNCH;
            gnt        <= N_REQ'(1) << win_idx;
            rr_ptr     <= win_idx;
            tmo_cnt    <= '0;
            m_new_txn  <= 1'b1;
            m_wr_en    <= win_cmd.wr;
            m_slv_addr <= win_cmd.slv;
            m_reg_addr <= win_cmd.rga;
            m_data     <= win_cmd.wdat;
          end
        end
        LAUNCH: begin
          if (m_busy) begin
            state     <= WAIT_DONE;
            m_new_txn <= 1'b0;
            tmo_cnt   <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= COMPLETE;
            m_new_txn <= 1'b0;
            done      <= gnt;
            err       <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!m_busy) begin
            state <= COMPLETE;
            done  <= gnt;
            err   <= {1'b0, m_nack};
            if (!m_wr_en) rdata <= m_rdata;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= COMPLETE;
            done  <= gnt;
            err   <= 2'b10;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        COMPLETE: begin
          state <= IDLE;
          gnt   <= '0;
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          m_new_txn <= 1'b0;
        end
      endcase
    end
  end
endmodule
